// File: rtl/intr_ctrl.sv
// Interrupt front-end: synchronises two external IRQ lines, latches them as pending,
// and presents one prioritised request to the control unit with an ack/hold-off handshake.
module intr_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int HOLDOFF     = 4
) (
  input  logic       clk,
  input  logic       a_reset,
  input  logic [1:0] ext_irq,
  input  logic       mie,
  input  logic       idle,
  input  logic       int0_ack,
  input  logic       int1_ack,
  output logic       int0,
  output logic       int1,
  output logic       intr_en,
  output logic [1:0] irq_pending,
  output logic       sleeping
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

  logic [SYNC_STAGES-1:0][1:0] sync_r;
  logic [1:0] hist_r;
  logic [1:0] pending_r;
  logic       sleeping_r;
  state_t     state_r;
  logic       sel_r;
  logic [3:0] cnt_r;

  logic [1:0] sync_out_s;
  logic [1:0] rise_s;
  logic [1:0] clr_s;
  logic [1:0] pending_nxt_s;
  logic       accept_s;
  logic       elig_s;

  assign sync_out_s  = sync_r[SYNC_STAGES-1];
  assign irq_pending = pending_r;
  assign sleeping    = sleeping_r;

  // Synchroniser chains plus one history stage used for rise detection
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      sync_r <= '0;
      hist_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ext_irq};
      hist_r <= sync_out_s;
    end
  end

  // Ack acceptance, pending next-state and eligibility
  always_comb begin
    accept_s      = 1'b0;
    clr_s         = 2'b00;
    rise_s        = sync_out_s & ~hist_r;
    pending_nxt_s = pending_r;
    if (state_r == ST_REQ) begin
      accept_s = sel_r ? int1_ack : int0_ack;
    end else begin
      accept_s = 1'b0;
    end
    if (accept_s) begin
      clr_s[sel_r] = 1'b1;
    end else begin
      clr_s = 2'b00;
    end
    // A rise coinciding with the clearing ack wins, so no edge is lost
    if (EDGE_MODE != 0) begin
      pending_nxt_s = rise_s | (pending_r & ~clr_s);
    end else begin
      pending_nxt_s = sync_out_s;
    end
    elig_s = |(pending_r & {2{mie | sleeping_r}});
  end

  // Pending flags and WFI sleep state
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      pending_r  <= 2'b00;
      sleeping_r <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      if (accept_s) begin
        sleeping_r <= 1'b0;
      end else if (idle) begin
        sleeping_r <= 1'b1;
      end else begin
        sleeping_r <= sleeping_r;
      end
    end
  end

  // Request FSM with registered outputs; the request stays until its own ack
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_r <= ST_IDLE;
      sel_r   <= 1'b0;
      cnt_r   <= 4'd0;
      intr_en <= 1'b0;
      int0    <= 1'b0;
      int1    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (elig_s) begin
            sel_r   <= ~pending_r[0];
            state_r <= ST_REQ;
            intr_en <= 1'b1;
            int0    <= pending_r[0];
            int1    <= ~pending_r[0];
          end else begin
            intr_en <= 1'b0;
            int0    <= 1'b0;
            int1    <= 1'b0;
          end
        end
        ST_REQ: begin
          if (accept_s) begin
            state_r <= ST_HOLD;
            cnt_r   <= HOLD_LOAD;
            intr_en <= 1'b0;
            int0    <= 1'b0;
            int1    <= 1'b0;
          end else begin
            intr_en <= 1'b1;
            int0    <= ~sel_r;
            int1    <= sel_r;
          end
        end
        ST_HOLD: begin
          intr_en <= 1'b0;
          int0    <= 1'b0;
          int1    <= 1'b0;
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            cnt_r <= 4'd0;
          end
          if (cnt_r <= 4'd1) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          intr_en <= 1'b0;
          int0    <= 1'b0;
          int1    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: cycle table driven through a scoreboard queue,
// plus hand-written sequences for level mode and asynchronous reset during a request.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       a_reset = 1'b1;
  logic [1:0] ext_irq = 2'b00;
  logic       mie = 1'b0;
  logic       idle = 1'b0;
  logic       int0_ack = 1'b0;
  logic       int1_ack = 1'b0;

  logic       int0, int1, intr_en, sleeping;
  logic [1:0] irq_pending;
  logic       lvl_int0, lvl_int1, lvl_intr_en, lvl_sleeping;
  logic [1:0] lvl_irq_pending;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1), .HOLDOFF(4)) dut (
    .clk(clk), .a_reset(a_reset), .ext_irq(ext_irq), .mie(mie), .idle(idle),
    .int0_ack(int0_ack), .int1_ack(int1_ack), .int0(int0), .int1(int1),
    .intr_en(intr_en), .irq_pending(irq_pending), .sleeping(sleeping)
  );

  intr_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(0), .HOLDOFF(4)) dut_lvl (
    .clk(clk), .a_reset(a_reset), .ext_irq(ext_irq), .mie(mie), .idle(idle),
    .int0_ack(int0_ack), .int1_ack(int1_ack), .int0(lvl_int0), .int1(lvl_int1),
    .intr_en(lvl_intr_en), .irq_pending(lvl_irq_pending), .sleeping(lvl_sleeping)
  );

  // req field is {intr_en, int1, int0}
  typedef struct packed {
    logic       rst;
    logic [1:0] irq;
    logic       mie;
    logic       idle;
    logic       a0;
    logic       a1;
    logic [2:0] req;
    logic [1:0] pend;
    logic       slp;
  } vec_t;

  typedef struct packed {
    logic [2:0] req;
    logic [1:0] pend;
    logic       slp;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] irq, input logic m,
                              input logic idl, input logic a0, input logic a1,
                              input logic [2:0] req, input logic [1:0] pend, input logic slp);
    vec_t v;
    v.rst = rst; v.irq = irq; v.mie = m; v.idle = idl; v.a0 = a0; v.a1 = a1;
    v.req = req; v.pend = pend; v.slp = slp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end else begin
      passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t got;
    exp_t want;
    int   cnt;
    bit   found;

    // Reset with both lines high; pending appears 3 edges after release
    tbl.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b11, 1'b0));
    // Line 1 pulse, request, ack, four-cycle hold-off
    tbl.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    // Both lines together: line 0 first, line 1 after hold-off; ack in HOLD ignored
    tbl.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b11, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 2'b11, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 2'b10, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0));
    // mie=0: no request until idle puts the hart to sleep; ack in IDLE ignored
    tbl.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b01, 1'b1));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 2'b01, 1'b1));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0));
    // Wrong-line ack and mie drop keep the request; rise coincident with ack re-pends
    tbl.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b101, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'b01, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 2'b01, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0));

    foreach (tbl[i]) begin
      @(negedge clk);
      a_reset  = tbl[i].rst;
      ext_irq  = tbl[i].irq;
      mie      = tbl[i].mie;
      idle     = tbl[i].idle;
      int0_ack = tbl[i].a0;
      int1_ack = tbl[i].a1;
      exp_q.push_back({tbl[i].req, tbl[i].pend, tbl[i].slp});
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = {intr_en, int1, int0, irq_pending, sleeping};
      check($sformatf("row%0d", i), 32'(got), 32'(want));
    end

    // Level mode: line held high through the ack re-requests after hold-off
    @(negedge clk);
    a_reset = 1'b1; ext_irq = 2'b00; mie = 1'b1; idle = 1'b0;
    int0_ack = 1'b0; int1_ack = 1'b0;
    @(negedge clk);
    a_reset = 1'b0; ext_irq = 2'b10;
    cnt = 99; found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(posedge clk); #1;
      if (lvl_intr_en) begin found = 1'b1; cnt = k; end
    end
    check("lvl_req_latency", 32'(cnt), 32'd4);
    check("lvl_req_line", 32'({lvl_int1, lvl_int0}), 32'd2);
    @(negedge clk);
    int1_ack = 1'b1;
    @(posedge clk); #1;
    check("lvl_ack_drop", 32'(lvl_intr_en), 32'd0);
    check("lvl_pending_kept", 32'(lvl_irq_pending), 32'd2);
    @(negedge clk);
    int1_ack = 1'b0;
    cnt = 99; found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(posedge clk); #1;
      if (lvl_intr_en) begin found = 1'b1; cnt = k; end
    end
    check("lvl_rereq_delay", 32'(cnt), 32'd5);
    check("lvl_rereq_line", 32'({lvl_int1, lvl_int0}), 32'd2);

    // Asynchronous reset mid-request drops it without waiting for a clock edge
    #2;
    a_reset = 1'b1;
    #1;
    check("async_rst_req", 32'({lvl_intr_en, lvl_int1, lvl_int0}), 32'd0);
    check("async_rst_pend", 32'(lvl_irq_pending), 32'd0);
    @(negedge clk);
    a_reset = 1'b0;
    ext_irq = 2'b00;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
